l2b_sio_resp_rcv: RTL

SIO-side receiver for one L2 bank's outbound response channel (l2bN_sio_ctag_vld / data / parity / ue_err); one instance per bank.
- Collects each 17-beat response packet: 1 header beat followed by 16 data beats.
- Checks per-halfword parity, accumulates uncorrectable-error status and buffers complete packets.
- Forwards packets store-and-forward over a valid/ready stream to the SIO outbound arbiter.
- Returns one credit to the L2 bank per drained packet.

---
 rtl/l2b_sio_resp_rcv.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/l2b_sio_resp_rcv.sv
// SIO-side receiver for one L2 bank response channel.
// Collects 17-beat packets (header plus 16 data beats), checks halfword parity,
// accumulates UE status, buffers whole packets in a small slot ring, and forwards
// them store-and-forward over a valid/ready stream. Each drained packet returns
// one credit to the L2 bank.
module l2b_sio_resp_rcv #(
    parameter int PKT_SLOTS = 2,
    parameter int CTAG_W    = 16
) (
    input  logic              iol2clk,
    input  logic              rst_l,
    input  logic              l2b_sio_ctag_vld,
    input  logic [31:0]       l2b_sio_data,
    input  logic [1:0]        l2b_sio_parity,
    input  logic              l2b_sio_ue_err,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [31:0]       out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [CTAG_W-1:0] out_ctag,
    output logic              out_ue,
    output logic              out_perr,
    output logic              sio_l2b_credit,
    output logic              ovf_err,
    output logic              proto_err
);

    localparam int PTR_W = (PKT_SLOTS > 1) ? $clog2(PKT_SLOTS) : 1;
    localparam int OCC_W = $clog2(PKT_SLOTS + 1);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(PKT_SLOTS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PKT_SLOTS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_DROP} rx_state_t;

    rx_state_t rx_state, rx_state_nxt;
    logic [3:0] wr_cnt;
    logic [3:0] rd_cnt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, commit_ptr;
    logic commit_vld;
    logic [OCC_W-1:0] occ;
    logic [PKT_SLOTS-1:0] slot_full;

    logic [31:0]       slot_data [PKT_SLOTS][16];
    logic [CTAG_W-1:0] slot_ctag [PKT_SLOTS];
    logic [PKT_SLOTS-1:0] slot_ue, slot_perr;

    logic [CTAG_W-1:0] cur_ctag;
    logic cur_ue, cur_perr;

    logic par_mis, hdr_beat, data_beat, fill_done, xfer, drain_done, slot_free;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Beat classification. A strobe seen while a packet is in progress is not a header.
    assign par_mis    = (^l2b_sio_data[31:16] != l2b_sio_parity[1]) ||
                        (^l2b_sio_data[15:0]  != l2b_sio_parity[0]);
    assign hdr_beat   = (rx_state == RX_IDLE) && l2b_sio_ctag_vld;
    assign data_beat  = (rx_state != RX_IDLE);
    assign fill_done  = (rx_state == RX_COLLECT) && (wr_cnt == 4'd15);
    assign xfer       = out_vld && out_rdy;
    assign drain_done = xfer && (rd_cnt == 4'd15);
    // The head slot emptying on this edge can take a header on the same edge.
    assign slot_free  = (occ != OCC_MAX) || drain_done;

    // Receive FSM next-state: header decides collect vs drop, 16 data beats return to idle.
    always_comb begin
        // NOTE: default assignment first so no path leaves rx_state_nxt unassigned (no latch).
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:            if (l2b_sio_ctag_vld) rx_state_nxt = slot_free ? RX_COLLECT : RX_DROP;
            RX_COLLECT, RX_DROP: if (wr_cnt == 4'd15) rx_state_nxt = RX_IDLE;
            default:            rx_state_nxt = RX_IDLE;
        endcase
    end

    // Receive FSM state and data-beat counter.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
        if (!rst_l) begin
            rx_state <= RX_IDLE;
            wr_cnt   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            wr_cnt   <= data_beat ? wr_cnt + 4'd1 : 4'd0;
        end
    end

    // Per-packet ctag/status accumulation and sticky protocol errors.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            cur_ctag  <= '0;
            cur_ue    <= 1'b0;
            cur_perr  <= 1'b0;
            ovf_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (hdr_beat) begin
                cur_ctag <= l2b_sio_data[CTAG_W-1:0];
                cur_perr <= par_mis;
                cur_ue   <= 1'b0;
            end else if (data_beat) begin
                cur_perr <= cur_perr | par_mis;
                cur_ue   <= cur_ue | l2b_sio_ue_err;
            end
            if (hdr_beat && !slot_free) ovf_err <= 1'b1;
            if (data_beat && l2b_sio_ctag_vld) proto_err <= 1'b1;
        end
    end

    // Slot storage: data beats land directly in the write slot, metadata on the last beat.
    always_ff @(posedge iol2clk) begin
        // NOTE: payload storage is not reset; the full flags gate every read, so stale contents never reach the outputs.
        if (rx_state == RX_COLLECT) slot_data[wr_ptr][wr_cnt] <= l2b_sio_data;
        if (fill_done) begin
            slot_ctag[wr_ptr] <= cur_ctag;
            slot_ue[wr_ptr]   <= cur_ue | l2b_sio_ue_err;
            slot_perr[wr_ptr] <= cur_perr | par_mis;
        end
    end

    // Ring pointers, occupancy, full flags (set one edge after fill), read beat count, credit.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            commit_ptr     <= '0;
            commit_vld     <= 1'b0;
            occ            <= '0;
            slot_full      <= '0;
            rd_cnt         <= '0;
            sio_l2b_credit <= 1'b0;
        end else begin
            commit_vld     <= fill_done;
            sio_l2b_credit <= drain_done;
            if (fill_done) begin
                wr_ptr     <= ptr_inc(wr_ptr);
                commit_ptr <= wr_ptr;
            end
            if (drain_done) begin
                rd_ptr            <= ptr_inc(rd_ptr);
                slot_full[rd_ptr] <= 1'b0;
            end
            if (commit_vld) slot_full[commit_ptr] <= 1'b1;
            if (fill_done && !drain_done) occ <= occ + 1'b1;
            else if (drain_done && !fill_done) occ <= occ - 1'b1;
            if (xfer) rd_cnt <= rd_cnt + 4'd1;
        end
    end

    // Output stream reads the head slot; everything is zero while no packet is ready.
    assign out_vld  = slot_full[rd_ptr];
    assign out_data = out_vld ? slot_data[rd_ptr][rd_cnt] : '0;
    assign out_ctag = out_vld ? slot_ctag[rd_ptr] : '0;
    assign out_ue   = out_vld & slot_ue[rd_ptr];
    assign out_perr = out_vld & slot_perr[rd_ptr];
    assign out_sop  = out_vld && (rd_cnt == 4'd0);
    assign out_eop  = out_vld && (rd_cnt == 4'd15);

endmodule
